eth_tx_rmii: RTL
================

// Module: eth_tx_rmii
// PURPOSE
//  Transmit stage downstream of the ARP/IP handlers: latches a fully packed st_eth_packet
//  (dest MAC, src MAC, ethertype, padded payload) and serialises it onto the 50 MHz RMII
//  TX pins as preamble + SFD + packet bytes + CRC-32 FCS, then enforces inter-frame gap.
//  Produces the physical frame; no re-ordering, no buffering beyond one packet.
// PARAMETERS
//  PACKET_BYTES  60  bytes in eth_packet (14 header + 46 min payload); FCS excluded
//  PREAMBLE_LEN  7   number of 0x55 preamble bytes before SFD 0xD5
//  IFG_CYCLES    48  eth_clk cycles tx_en held low after FCS (12 bytes at 2 bits/cycle)
// PORTS
//  eth_clk      in   1                 50 MHz RMII reference clock; all logic on rising edge
//  rst_n_in     in   1                 asynchronous, active-low reset
//  send_packet  in   1                 request; level signal, acted on at its rising edge only
//  eth_packet   in   PACKET_BYTES*8    packet; bits [PACKET_BYTES*8-1 -: 8] are first byte on wire
//  busy         out  1                 high from accept until IFG complete
//  drop_pulse   out  1                 1-cycle pulse: rising edge of send_packet seen while busy
//  tx_en        out  1                 RMII TX_EN
//  txd          out  2                 RMII TXD[1:0]
// BEHAVIOUR
//  - Reset (async assert, sync release): tx_en=0, txd=2'b00, busy=0, drop_pulse=0,
//    state=IDLE, send_packet edge register=0, CRC=32'hFFFF_FFFF. Mid-frame reset aborts
//    immediately (tx_en drops asynchronously); no partial frame resumes.
//  - Edge detect: req = send_packet & ~send_packet_q. Level held high issues exactly one frame.
//  - Accept: in IDLE, req latches eth_packet into shadow register, busy=1 next cycle.
//    req while busy -> ignored, drop_pulse=1 for one cycle.
//  - Latency: accept at cycle N -> tx_en=1 with first preamble dibit at N+1.
//  - Byte order: packet bytes MSB-byte first; within each byte dibits LSB first
//    (cycle k of a byte drives bits [2k+1:2k], k=0..3).
//  - FSM: IDLE -> PREAMBLE (PREAMBLE_LEN*4 cycles, txd=2'b01) -> SFD (4 cycles: 01,01,01,11)
//    -> DATA (PACKET_BYTES*4 cycles) -> FCS (16 cycles) -> IFG (IFG_CYCLES, tx_en=0, txd=00)
//    -> IDLE. busy deasserts on the IFG->IDLE cycle; new req accepted that same cycle.
//  - tx_en=1 exactly (PREAMBLE_LEN+1+PACKET_BYTES+4)*4 contiguous cycles; 288 at defaults.
//  - CRC-32 (IEEE, reflected poly 32'hEDB88320), init 32'hFFFF_FFFF at accept, updated
//    2 bits/cycle over DATA dibits only (not preamble/SFD). FCS = ~crc, sent bit 0 first
//    (i.e. FCS bytes LSB-byte first, each byte LSB dibit first).
//  - Counters: byte counter sized $clog2(PACKET_BYTES+1), dibit counter 2 bits; no wrap
//    beyond terminal count, each state loads its own terminal.
//  - eth_packet may change freely after the accept cycle; frame uses shadow copy only.
//  - tx_en, txd are registered outputs (no combinational path from inputs).
// TESTING
//  1 Reset: hold rst_n_in=0 with send_packet=1 -> tx_en=0, txd=00, busy=0; release, keep
//    send_packet=1 -> no frame (no rising edge).
//  2 CRC check: PACKET_BYTES=9, eth_packet="123456789" (8'h31 first), pulse send_packet
//    -> data dibits match ASCII, FCS bytes 8'h26,8'h39,8'hF4,8'hCB (CRC 32'hCBF43926).
//  3 Default ARP reply frame (dest 48'hff.. swapped, src 48'h123456789abc, type 16'h0806)
//    -> 28 preamble dibits 01, SFD 01,01,01,11, tx_en high 288 cycles, first data byte
//    on wire = eth_packet[479:472]; bench reference model CRC matches.
//  4 Back-to-back: second rising edge mid-frame -> drop_pulse once, no second frame;
//    edge on IFG->IDLE cycle -> accepted, tx_en gap exactly IFG_CYCLES=48.
//  5 Abort: assert rst_n_in low at DATA byte 20 -> tx_en=0 same cycle; after release and new
//    edge, full fresh frame with correct FCS.
//  6 Shadow: change eth_packet every cycle after accept -> transmitted bytes equal value at accept.

Source files
------------

// File: rtl/eth_tx_rmii.sv
// RMII transmit stage: latches one packed Ethernet packet and sends it as
// preamble + SFD + packet bytes + CRC-32 FCS, then holds the inter-frame gap.
module eth_tx_rmii #(
    parameter int PACKET_BYTES = 60,
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_CYCLES   = 48
) (
    input  logic                      eth_clk,
    input  logic                      rst_n_in,
    input  logic                      send_packet,
    input  logic [PACKET_BYTES*8-1:0] eth_packet,
    output logic                      busy,
    output logic                      drop_pulse,
    output logic                      tx_en,
    output logic [1:0]                txd
);

    // byte counter also walks the preamble, so size it for whichever is longer
    localparam int BMAX = (PACKET_BYTES > PREAMBLE_LEN) ? PACKET_BYTES : PREAMBLE_LEN;
    localparam int BW   = $clog2(BMAX + 1);
    localparam int GW   = $clog2(IFG_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_FCS, S_IFG} state_t;

    // reflected CRC-32, two bits per call, txd[0] is the earlier bit on the wire
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    logic [1:0]                rst_sync_q, rst_sync_d;
    logic                      rst_n;
    state_t                    state_q, state_d, nxt;
    logic [BW-1:0]             byte_q, byte_d, term;
    logic [1:0]                dibit_q, dibit_d;
    logic [GW-1:0]             ifg_q, ifg_d;
    logic [31:0]               crc_q, crc_d;
    logic [PACKET_BYTES*8-1:0] shadow_q, shadow_d;
    logic                      send_q, send_d;
    logic                      primed_q, primed_d;
    logic                      busy_q, busy_d;
    logic                      drop_q, drop_d;
    logic                      tx_en_q, tx_en_d;
    logic [1:0]                txd_q, txd_d;
    logic [7:0]                data_byte;
    logic [1:0]                data_dibit;
    logic                      req, ifg_last, accept;

    // reset asserts immediately, releases two clocks later on a clean edge
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    // reset synchroniser flops
    always_ff @(posedge eth_clk or negedge rst_n_in) begin
        if (!rst_n_in) rst_sync_q <= 2'b00;
        else           rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    // primed_q masks the first cycle after reset so a request level held
    // through reset is only sampled, never taken as a rising edge
    assign req      = send_packet & ~send_q & primed_q;
    assign ifg_last = (state_q == S_IFG) && (ifg_q == GW'(IFG_CYCLES - 1));
    assign accept   = req && ((state_q == S_IDLE) || ifg_last);

    // all state and registered outputs
    always_ff @(posedge eth_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            byte_q   <= '0;
            dibit_q  <= '0;
            ifg_q    <= '0;
            crc_q    <= 32'hFFFF_FFFF;
            shadow_q <= '0;
            send_q   <= 1'b0;
            primed_q <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
            tx_en_q  <= 1'b0;
            txd_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            byte_q   <= byte_d;
            dibit_q  <= dibit_d;
            ifg_q    <= ifg_d;
            crc_q    <= crc_d;
            shadow_q <= shadow_d;
            send_q   <= send_d;
            primed_q <= primed_d;
            busy_q   <= busy_d;
            drop_q   <= drop_d;
            tx_en_q  <= tx_en_d;
            txd_q    <= txd_d;
        end
    end

    // next position in the frame, then the pins/CRC for that next position
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        dibit_d    = dibit_q;
        ifg_d      = ifg_q;
        crc_d      = crc_q;
        shadow_d   = shadow_q;
        send_d     = send_packet;
        primed_d   = 1'b1;
        drop_d     = req && !accept && (state_q != S_IDLE);
        tx_en_d    = 1'b0;
        txd_d      = 2'b00;
        term       = '0;
        nxt        = S_IDLE;
        data_byte  = '0;
        data_dibit = '0;

        case (state_q)
            S_PRE:   begin term = BW'(PREAMBLE_LEN - 1); nxt = S_SFD;  end
            S_SFD:   begin term = '0;                    nxt = S_DATA; end
            S_DATA:  begin term = BW'(PACKET_BYTES - 1); nxt = S_FCS;  end
            S_FCS:   begin term = BW'(3);                nxt = S_IFG;  end
            default: ;
        endcase

        case (state_q)
            S_PRE, S_SFD, S_DATA, S_FCS: begin
                dibit_d = dibit_q + 2'd1;
                if (dibit_q == 2'd3) begin
                    if (byte_q == term) begin
                        state_d = nxt;
                        byte_d  = '0;
                        ifg_d   = '0;
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end
            S_IFG: begin
                if (ifg_last) state_d = S_IDLE;
                else          ifg_d   = ifg_q + 1'b1;
            end
            default: ;
        endcase

        if (accept) begin
            state_d  = S_PRE;
            byte_d   = '0;
            dibit_d  = '0;
            shadow_d = eth_packet;
            crc_d    = 32'hFFFF_FFFF;
        end

        data_byte  = shadow_q[8*(PACKET_BYTES - 1 - int'(byte_d)) +: 8];
        data_dibit = data_byte[2*dibit_d +: 2];

        case (state_d)
            S_PRE: begin
                tx_en_d = 1'b1;
                txd_d   = 2'b01;
            end
            S_SFD: begin
                tx_en_d = 1'b1;
                txd_d   = (dibit_d == 2'd3) ? 2'b11 : 2'b01;
            end
            S_DATA: begin
                tx_en_d = 1'b1;
                txd_d   = data_dibit;
                crc_d   = crc_dibit(crc_q, data_dibit);
            end
            S_FCS: begin
                // CRC is final on entry; shift it out inverted, bit 0 first
                tx_en_d = 1'b1;
                txd_d   = ~crc_q[1:0];
                crc_d   = {2'b11, crc_q[31:2]};
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign busy       = busy_q;
    assign drop_pulse = drop_q;
    assign tx_en      = tx_en_q;
    assign txd        = txd_q;

endmodule
